count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/cnt_arb_pkg.sv | 22 ++
 rtl/count_arbiter_rr_arb2.sv | 25 ++
 rtl/count_arbiter.sv | 119 +++++++++++
 tb/tb_count_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the two-requester counting arbiter.
package cnt_arb_pkg;

    // Default counter width in bits.
    localparam int CNT_W_DEF = 4;

    // Number of requesters served by the arbiter.
    localparam int NREQ = 2;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot requester mask for a requester index.
    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : cnt_arb_pkg

// File: rtl/count_arbiter_rr_arb2.sv
// Two-input round-robin grant logic.
// The grant is purely combinational. i_advance marks the cycles in which a
// grant may be issued, i.e. in which the priority pointer is allowed to move.
// i_prio selects the requester that wins when both are valid.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Single valid wins outright; contention is resolved by the priority bit.
    always_comb begin
        o_grant = '0;
        if (i_advance) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_prio ? 2'b10 : 2'b01;
                default: o_grant = '0;
            endcase
        end
    end

endmodule : rr_arb2

// File: rtl/count_arbiter.sv
// Shared up/down counter time-multiplexed between two requesters.
// A granted command loads the counter, which then steps once per cycle
// toward the captured target; completion is reported with a one-cycle
// done pulse to the owner before the arbiter returns to IDLE.
module count_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [CNT_W-1:0] req0_start,
    input  logic [CNT_W-1:0] req1_start,
    input  logic [CNT_W-1:0] req0_target,
    input  logic [CNT_W-1:0] req1_target,
    input  logic             req0_up,
    input  logic             req1_up,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             owner,
    output logic [NREQ-1:0]  done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;
    logic             r_up;
    logic             r_owner;
    logic             r_busy;
    logic [NREQ-1:0]  r_done;
    logic             r_prio;

    logic [NREQ-1:0]  w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_gidx;
    logic [CNT_W-1:0] w_sel_start;
    logic [CNT_W-1:0] w_sel_target;
    logic             w_sel_up;

    assign w_idle = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .i_valid   (req_valid),
        .i_prio    (r_prio),
        .i_advance (w_idle),
        .o_grant   (w_grant)
    );

    // The grant is already masked by valid, so any grant bit is a transfer.
    assign w_accept = |w_grant;
    assign w_gidx   = w_grant[1];

    // Command fields of the winning requester.
    always_comb begin
        w_sel_start  = w_gidx ? req1_start  : req0_start;
        w_sel_target = w_gidx ? req1_target : req0_target;
        w_sel_up     = w_gidx ? req1_up     : req0_up;
    end

    // Controller: acceptance and capture, counting, completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_up     <= 1'b0;
            r_owner  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= '0;
            r_prio   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_count  <= w_sel_start;
                        r_target <= w_sel_target;
                        r_up     <= w_sel_up;
                        r_owner  <= w_gidx;
                        r_busy   <= 1'b1;
                        r_prio   <= ~w_gidx;
                    end
                end
                RUN: begin
                    if (r_count == r_target) begin
                        r_state <= DONE;
                        r_done  <= req_onehot(r_owner);
                    end else if (r_up) begin
                        r_count <= r_count + ONE;
                    end else begin
                        r_count <= r_count - ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_grant;
    assign count     = r_count;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign done      = r_done;

endmodule : count_arbiter

// File: tb/tb_count_arbiter.sv
// Directed self-checking bench for count_arbiter.
module tb_count_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_start, req1_start, req0_target, req1_target;
    logic       req0_up, req1_up;
    logic [3:0] count;
    logic       busy;
    logic       owner;
    logic [1:0] done;

    int checks = 0;
    int errors = 0;

    count_arbiter #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_start  (req0_start),
        .req1_start  (req1_start),
        .req0_target (req0_target),
        .req1_target (req1_target),
        .req0_up     (req0_up),
        .req1_up     (req1_up),
        .count       (count),
        .busy        (busy),
        .owner       (owner),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 2'b00;
        req0_start = 4'd0; req0_target = 4'd0; req0_up = 1'b0;
        req1_start = 4'd0; req1_target = 4'd0; req1_up = 1'b0;
        tick; tick;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL rst_done: got %b expected 00", done); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b expected 0", owner); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_up;
        req0_start = 4'd3; req0_target = 4'd6; req0_up = 1'b1;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL up_ready: got %b expected 01", req_ready); end
        tick;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL up_load: got %0d expected 3", count); end
        checks++; if (busy !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL up_busy_owner: got %b/%b expected 1/0", busy, owner); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL up_ready_run: got %b expected 00", req_ready); end
        req_valid = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++; if (count !== 4'(3 + k) || done !== 2'b00) begin errors++; $display("FAIL up_step%0d: got count %0d done %b expected %0d 00", k, count, done, 3 + k); end
        end
        tick;
        checks++; if (done !== 2'b01 || count !== 4'd6) begin errors++; $display("FAIL up_done: got done %b count %0d expected 01 6", done, count); end
        tick;
        checks++; if (done !== 2'b00 || busy !== 1'b0 || count !== 4'd6) begin errors++; $display("FAIL up_idle: got done %b busy %b count %0d expected 00 0 6", done, busy, count); end
    endtask

    task automatic test_down_wrap;
        logic [3:0] seq [4];
        seq = '{4'd1, 4'd0, 4'd15, 4'd14};
        req1_start = 4'd2; req1_target = 4'd14; req1_up = 1'b0;
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL dn_ready: got %b expected 10", req_ready); end
        tick;
        checks++; if (count !== 4'd2 || owner !== 1'b1) begin errors++; $display("FAIL dn_load: got count %0d owner %b expected 2 1", count, owner); end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (count !== seq[k] || done !== 2'b00) begin errors++; $display("FAIL dn_step%0d: got count %0d done %b expected %0d 00", k, count, done, seq[k]); end
        end
        tick;
        checks++; if (done !== 2'b10 || count !== 4'd14) begin errors++; $display("FAIL dn_done: got done %b count %0d expected 10 14", done, count); end
        tick;
        checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL dn_idle: got done %b busy %b expected 00 0", done, busy); end
    endtask

    task automatic test_alternate;
        logic exp;
        reset = 1'b1;
        req0_start = 4'd5; req0_target = 4'd5; req0_up = 1'b1;
        req1_start = 4'd5; req1_target = 4'd5; req1_up = 1'b1;
        req_valid = 2'b11;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL alt_first_ready: got %b expected 01", req_ready); end
        for (int g = 0; g < 4; g++) begin
            exp = 1'(g % 2);
            tick;
            checks++; if (owner !== exp || busy !== 1'b1 || count !== 4'd5) begin errors++; $display("FAIL alt_accept%0d: got owner %b busy %b count %0d expected %b 1 5", g, owner, busy, count, exp); end
            tick;
            checks++; if (done !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_done%0d: got %b expected %b", g, done, exp ? 2'b10 : 2'b01); end
            tick;
            checks++; if (done !== 2'b00 || busy !== 1'b0 || req_ready !== (exp ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_idle%0d: got done %b busy %b ready %b expected 00 0 %b", g, done, busy, req_ready, exp ? 2'b01 : 2'b10); end
        end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_reset_mid_run;
        req0_start = 4'd0; req0_target = 4'd10; req0_up = 1'b1;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        repeat (4) tick;
        checks++; if (count !== 4'd4 || busy !== 1'b1) begin errors++; $display("FAIL mid_before: got count %0d busy %b expected 4 1", count, busy); end
        reset = 1'b1;
        #1;
        checks++; if (count !== 4'd0 || busy !== 1'b0 || done !== 2'b00 || owner !== 1'b0) begin errors++; $display("FAIL mid_async: got count %0d busy %b done %b owner %b expected 0 0 00 0", count, busy, done, owner); end
        tick;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL mid_nodone%0d: got done %b busy %b expected 00 0", k, done, busy); end
        end
        req0_start = 4'd7; req0_target = 4'd7;
        req1_start = 4'd7; req1_target = 4'd7;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_prio_ready: got %b expected 01", req_ready); end
        tick;
        checks++; if (owner !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reaccept: got owner %b busy %b expected 0 1", owner, busy); end
        req_valid = 2'b00;
        tick; tick;
    endtask

    task automatic test_capture;
        req0_start = 4'd1; req0_target = 4'd3; req0_up = 1'b1;
        req_valid = 2'b01;
        tick;
        checks++; if (owner !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL cap_load: got owner %b count %0d expected 0 1", owner, count); end
        req0_start = 4'd9; req0_target = 4'd0; req0_up = 1'b0;
        req1_start = 4'd12; req1_target = 4'd12; req1_up = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cap_ready_run: got %b expected 00", req_ready); end
        for (int k = 1; k <= 2; k++) begin
            tick;
            checks++; if (count !== 4'(1 + k) || req_ready !== 2'b00) begin errors++; $display("FAIL cap_step%0d: got count %0d ready %b expected %0d 00", k, count, req_ready, 1 + k); end
        end
        tick;
        checks++; if (done !== 2'b01 || count !== 4'd3 || req_ready !== 2'b00) begin errors++; $display("FAIL cap_done: got done %b count %0d ready %b expected 01 3 00", done, count, req_ready); end
        tick;
        checks++; if (busy !== 1'b0 || done !== 2'b00 || req_ready !== 2'b10) begin errors++; $display("FAIL cap_idle: got busy %b done %b ready %b expected 0 00 10", busy, done, req_ready); end
        tick;
        checks++; if (owner !== 1'b1 || count !== 4'd12 || busy !== 1'b1) begin errors++; $display("FAIL cap_next: got owner %b count %0d busy %b expected 1 12 1", owner, count, busy); end
        req_valid = 2'b00;
        tick;
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL cap_next_done: got %b expected 10", done); end
        tick;
    endtask

    initial begin
        test_reset;
        test_up;
        test_down_wrap;
        test_alternate;
        test_reset_mid_run;
        test_capture;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_count_arbiter
